// File: rtl/systolic_tile_scheduler_pkg.sv
// strait_sched_pkg: scheduler FSM states and the result-latency helper shared by the tile scheduler.
package strait_sched_pkg;
    typedef enum logic [2:0] {IDLE, LOAD_W, COMPUTE, DRAIN, DONE} state_t;

    function automatic int result_lat(input int size);
        return 2 * size;
    endfunction
endpackage

// File: rtl/systolic_tile_scheduler_if.sv
// systolic_tile_scheduler_if: weight, activation and result streams of the tile scheduler.
interface systolic_tile_scheduler_if #(
    parameter int SYSTOLIC_SIZE     = 8,
    parameter int WEIGHT_WIDTH      = 8,
    parameter int ACTIVATION_WIDTH  = 8,
    parameter int PARTIAL_SUM_WIDTH = WEIGHT_WIDTH + ACTIVATION_WIDTH + $clog2(SYSTOLIC_SIZE)
);
    logic                                       w_valid;
    logic                                       w_ready;
    logic [SYSTOLIC_SIZE*WEIGHT_WIDTH-1:0]      w_data;
    logic                                       a_valid;
    logic                                       a_ready;
    logic [SYSTOLIC_SIZE*ACTIVATION_WIDTH-1:0]  a_data;
    logic                                       res_valid;
    logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0] res_data;

    modport master (
        output w_valid, w_data, a_valid, a_data,
        input  w_ready, a_ready, res_valid, res_data
    );

    modport slave (
        input  w_valid, w_data, a_valid, a_data,
        output w_ready, a_ready, res_valid, res_data
    );
endinterface

// File: rtl/systolic_tile_scheduler_skew_line.sv
// skew_line: fixed-depth register delay line; DEPTH=0 degenerates to a wire.
module skew_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    if (DEPTH == 0) begin : g_wire
        logic unused_clk;
        assign unused_clk = clk ^ rst;
        assign q = d;
    end else begin : g_reg
        logic [WIDTH-1:0] sr [DEPTH];
        always_ff @(posedge clk or posedge rst)
            if (rst) begin
                for (int k = 0; k < DEPTH; k++) sr[k] <= '0;
            end else begin
                sr[0] <= d;
                for (int k = 1; k < DEPTH; k++) sr[k] <= sr[k-1];
            end
        assign q = sr[DEPTH-1];
    end
endmodule

// File: rtl/systolic_tile_scheduler.sv
// systolic_tile_scheduler: loads one weight tile, streams row-skewed activations, de-skews bottom-row psums.
// Define STRAIT_SCHED_PERF_EN to add the perf_busy_cyc / perf_bubble_cyc counters.
module systolic_tile_scheduler
    import strait_sched_pkg::*;
#(
    parameter int SYSTOLIC_SIZE     = 8,
    parameter int WEIGHT_WIDTH      = 8,
    parameter int ACTIVATION_WIDTH  = 8,
    parameter int PARTIAL_SUM_WIDTH = WEIGHT_WIDTH + ACTIVATION_WIDTH + $clog2(SYSTOLIC_SIZE),
    parameter int CNT_WIDTH         = 16
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start,
    input  logic [CNT_WIDTH-1:0]                       num_vec,
    input  logic [SYSTOLIC_SIZE-1:0]                   pe_disable_cfg,
    output logic                                       busy,
    output logic                                       done,
    systolic_tile_scheduler_if.slave                   bus,
    output logic                                       sa_clk_w_en,
    output logic [SYSTOLIC_SIZE*WEIGHT_WIDTH-1:0]      sa_weight_flat,
    output logic [SYSTOLIC_SIZE*ACTIVATION_WIDTH-1:0]  sa_activation_flat,
    output logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0] sa_psum_in_flat,
    output logic [SYSTOLIC_SIZE-1:0]                   sa_pe_disable,
    input  logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0] sa_psum_out_flat
`ifdef STRAIT_SCHED_PERF_EN
    ,
    output logic [31:0]                                perf_busy_cyc,
    output logic [31:0]                                perf_bubble_cyc
`endif
);
    localparam int RESULT_LAT = result_lat(SYSTOLIC_SIZE);
    localparam int WCW = $clog2(SYSTOLIC_SIZE + 1);
    localparam logic [WCW-1:0] W_BEATS = WCW'(SYSTOLIC_SIZE);

    state_t                                    state;
    state_t                                    nxt;
    logic [WCW-1:0]                            w_cnt;
    logic [CNT_WIDTH-1:0]                      a_cnt;
    logic [CNT_WIDTH-1:0]                      num_q;
    logic [RESULT_LAT-1:0]                     vpipe;
    logic [SYSTOLIC_SIZE*ACTIVATION_WIDTH-1:0] act_q;
    logic [PARTIAL_SUM_WIDTH-1:0]              dsk [SYSTOLIC_SIZE];
    logic                                      w_ready;
    logic                                      a_ready;
    logic                                      w_acc;
    logic                                      a_acc;
    logic                                      launch;

    assign launch = state == IDLE && start;
    assign w_acc = bus.w_valid && w_ready;
    assign a_acc = bus.a_valid && a_ready;
    assign bus.w_ready = w_ready;
    assign bus.a_ready = a_ready;
    assign sa_psum_in_flat = '0;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= nxt;

    // Phase exits use the registered beat counts, so the last weight pulse lands before COMPUTE/DONE.
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? LOAD_W : IDLE;
            LOAD_W:  nxt = w_cnt != W_BEATS ? LOAD_W : num_q == '0 ? DONE : COMPUTE;
            COMPUTE: nxt = a_cnt == num_q ? DRAIN : COMPUTE;
            DRAIN:   nxt = vpipe == '0 ? DONE : DRAIN;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = state != IDLE && state != DONE;
        done = state == DONE;
        w_ready = state == LOAD_W && w_cnt != W_BEATS;
        a_ready = state == COMPUTE && a_cnt != num_q;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            w_cnt <= '0;
            a_cnt <= '0;
            num_q <= '0;
            sa_pe_disable <= '0;
            sa_weight_flat <= '0;
            sa_clk_w_en <= 1'b0;
            act_q <= '0;
            vpipe <= '0;
        end else begin
            w_cnt <= launch ? '0 : w_cnt + WCW'(w_acc);
            a_cnt <= launch ? '0 : a_cnt + CNT_WIDTH'(a_acc);
            num_q <= launch ? num_vec : num_q;
            sa_pe_disable <= launch ? pe_disable_cfg : sa_pe_disable;
            sa_weight_flat <= w_acc ? bus.w_data : sa_weight_flat;
            sa_clk_w_en <= w_acc;
            act_q <= a_acc ? bus.a_data : '0;
            vpipe <= {vpipe[RESULT_LAT-2:0], a_acc};
        end

    for (genvar i = 0; i < SYSTOLIC_SIZE; i++) begin : g_row
        skew_line #(.WIDTH(ACTIVATION_WIDTH), .DEPTH(i)) u_skew (
            .clk(clk),
            .rst(rst),
            .d(act_q[i*ACTIVATION_WIDTH +: ACTIVATION_WIDTH]),
            .q(sa_activation_flat[i*ACTIVATION_WIDTH +: ACTIVATION_WIDTH])
        );
    end

    // Column j leaves the array j cycles after column 0; pad it out to the common latency.
    for (genvar j = 0; j < SYSTOLIC_SIZE; j++) begin : g_col
        skew_line #(.WIDTH(PARTIAL_SUM_WIDTH), .DEPTH(SYSTOLIC_SIZE - 1 - j)) u_dskew (
            .clk(clk),
            .rst(rst),
            .d(sa_psum_out_flat[j*PARTIAL_SUM_WIDTH +: PARTIAL_SUM_WIDTH]),
            .q(dsk[j])
        );
        assign bus.res_data[j*PARTIAL_SUM_WIDTH +: PARTIAL_SUM_WIDTH] =
            bus.res_valid && !sa_pe_disable[j] ? dsk[j] : '0;
    end

    assign bus.res_valid = vpipe[RESULT_LAT-1];

`ifdef STRAIT_SCHED_PERF_EN
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            perf_busy_cyc <= '0;
            perf_bubble_cyc <= '0;
        end else if (launch) begin
            perf_busy_cyc <= '0;
            perf_bubble_cyc <= '0;
        end else begin
            perf_busy_cyc <= busy && ~&perf_busy_cyc ? perf_busy_cyc + 32'd1 : perf_busy_cyc;
            perf_bubble_cyc <= a_ready && !bus.a_valid && ~&perf_bubble_cyc ? perf_bubble_cyc + 32'd1 : perf_bubble_cyc;
        end
`endif
endmodule
